// File: rtl/ucsbece154b_mlane_fifo_if.sv
// Bus bundle for the multi-lane FIFO: push side, pop side and status.
// master = producer/consumer driving the FIFO, slave = the FIFO itself.
interface ucsbece154b_mlane_fifo_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NR_ENTRIES = 8,
   parameter int unsigned PUSH_LANES = 2,
   parameter int unsigned POP_LANES  = 2
);
   logic                                 flush_i;
   logic [PUSH_LANES*DATA_WIDTH-1:0]     data_i;
   logic [$clog2(PUSH_LANES+1)-1:0]      push_cnt_i;
   logic                                 push_ack_o;
   logic [POP_LANES*DATA_WIDTH-1:0]      data_o;
   logic [POP_LANES-1:0]                 valid_o;
   logic [$clog2(POP_LANES+1)-1:0]       pop_cnt_i;
   logic [$clog2(NR_ENTRIES+1)-1:0]      count_o;
   logic                                 full_o;
   logic                                 almost_full_o;

   modport master (
      output flush_i, data_i, push_cnt_i, pop_cnt_i,
      input  push_ack_o, data_o, valid_o, count_o, full_o, almost_full_o
   );

   modport slave (
      input  flush_i, data_i, push_cnt_i, pop_cnt_i,
      output push_ack_o, data_o, valid_o, count_o, full_o, almost_full_o
   );
endinterface

// File: rtl/ucsbece154b_mlane_fifo.sv
// Multi-lane synchronous FIFO: up to PUSH_LANES writes and POP_LANES reads
// per cycle, arbitrary depth, flush, occupancy count and almost-full flag.
module ucsbece154b_mlane_fifo #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NR_ENTRIES   = 8,
   parameter int unsigned PUSH_LANES   = 2,
   parameter int unsigned POP_LANES    = 2,
   parameter int unsigned AFULL_THRESH = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   ucsbece154b_mlane_fifo_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
   localparam int unsigned CNT_W = $clog2(NR_ENTRIES+1);
   // One extra bit so pointer/count sums up to 2*NR_ENTRIES never overflow.
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] DEPTH = SUM_W'(NR_ENTRIES);

   logic [DATA_WIDTH-1:0] mem_q [NR_ENTRIES];
   logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [SUM_W-1:0]      push_n, pop_req, pop_eff;
   logic                  push_ack;

   // Modulo-NR_ENTRIES reduction; operands are always below 2*NR_ENTRIES.
   function automatic logic [PTR_W-1:0] wrap(input logic [SUM_W-1:0] s);
      logic [SUM_W-1:0] r;
      r = (s >= DEPTH) ? s - DEPTH : s;
      return r[PTR_W-1:0];
   endfunction

   // Clamp pops, decide push acceptance, compute next pointers and count.
   always_comb begin
      push_n   = SUM_W'(bus.push_cnt_i);
      pop_req  = SUM_W'(bus.pop_cnt_i);
      pop_eff  = (pop_req < SUM_W'(count_q)) ? pop_req : SUM_W'(count_q);
      push_ack = !rst_i && !bus.flush_i && (push_n != '0) &&
                 (push_n <= DEPTH - SUM_W'(count_q) + pop_eff);
      head_d   = wrap(SUM_W'(head_q) + pop_eff);
      tail_d   = push_ack ? wrap(SUM_W'(tail_q) + push_n) : tail_q;
      count_d  = CNT_W'(SUM_W'(count_q) + (push_ack ? push_n : '0) - pop_eff);
   end

   // Pointer and occupancy registers; reset and flush both empty the queue.
   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage write: accepted lanes land at consecutive slots from the tail.
   always_ff @(posedge clk_i) begin
      if (push_ack) begin
         for (int unsigned k = 0; k < PUSH_LANES; k++) begin
            if (SUM_W'(k) < push_n)
               mem_q[wrap(SUM_W'(tail_q) + SUM_W'(k))] <= bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Read lanes: k-th oldest entry when present, zeros otherwise.
   always_comb begin
      bus.data_o  = '0;
      bus.valid_o = '0;
      for (int unsigned k = 0; k < POP_LANES; k++) begin
         if (SUM_W'(count_q) > SUM_W'(k)) begin
            bus.valid_o[k]                          = 1'b1;
            bus.data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[wrap(SUM_W'(head_q) + SUM_W'(k))];
         end
      end
   end

   assign bus.push_ack_o    = push_ack;
   assign bus.count_o       = count_q;
   assign bus.full_o        = (count_q == CNT_W'(NR_ENTRIES));
   assign bus.almost_full_o = (SUM_W'(count_q) >= SUM_W'(AFULL_THRESH));

endmodule

// File: tb/tb_ucsbece154b_mlane_fifo.sv
// Bench for the multi-lane FIFO: drives an 8-deep and a 5-deep instance with
// the same stimulus, each checked against its own queue-based reference.
module tb_ucsbece154b_mlane_fifo;
   typedef logic [31:0] q_t [$];

   typedef struct {
      logic        fl, rs;
      logic [1:0]  pc, pp;
      logic [31:0] d0, d1;
      logic        ack;
      int          cnt;
      logic [1:0]  v;
      logic [31:0] l0;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  push_cnt, pop_cnt;
   logic [63:0] data;
   int          checks = 0;
   int          errors = 0;
   q_t          q8, q5;
   vec_t        tbl [$];

   always #5 clk = ~clk;

   ucsbece154b_mlane_fifo_if #(.DATA_WIDTH(32), .NR_ENTRIES(8), .PUSH_LANES(2), .POP_LANES(2)) if8 ();
   ucsbece154b_mlane_fifo_if #(.DATA_WIDTH(32), .NR_ENTRIES(5), .PUSH_LANES(2), .POP_LANES(2)) if5 ();

   assign if8.flush_i = flush;  assign if5.flush_i = flush;
   assign if8.data_i = data;    assign if5.data_i = data;
   assign if8.push_cnt_i = push_cnt; assign if5.push_cnt_i = push_cnt;
   assign if8.pop_cnt_i = pop_cnt;   assign if5.pop_cnt_i = pop_cnt;

   ucsbece154b_mlane_fifo #(.DATA_WIDTH(32), .NR_ENTRIES(8), .PUSH_LANES(2), .POP_LANES(2),
                            .AFULL_THRESH(6)) dut8 (.clk_i(clk), .rst_i(rst), .bus(if8.slave));
   ucsbece154b_mlane_fifo #(.DATA_WIDTH(32), .NR_ENTRIES(5), .PUSH_LANES(2), .POP_LANES(2),
                            .AFULL_THRESH(4)) dut5 (.clk_i(clk), .rst_i(rst), .bus(if5.slave));

   logic [7:0] c8, c5;
   assign c8 = 8'(if8.count_o);
   assign c5 = 8'(if5.count_o);

   always @(posedge clk) begin
      assert (push_cnt <= 2'd2) else $error("push_cnt_i above PUSH_LANES");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic model_ack(input int size, input int n, input logic fl, input logic rs,
                                      input int pc, input int pp);
      int pe;
      pe = (pp < size) ? pp : size;
      return !rs && !fl && pc != 0 && pc <= n - size + pe;
   endfunction

   task automatic model_upd(input q_t qi, input int n, input logic fl, input logic rs,
                            input int pc, input int pp, input logic [63:0] d, output q_t qo);
      int   pe;
      logic a;
      qo = qi;
      a  = model_ack(qi.size(), n, fl, rs, pc, pp);
      if (rs || fl) qo.delete();
      else begin
         pe = (pp < qi.size()) ? pp : qi.size();
         repeat (pe) void'(qo.pop_front());
         if (a) begin
            if (pc >= 1) qo.push_back(d[31:0]);
            if (pc >= 2) qo.push_back(d[63:32]);
         end
      end
   endtask

   task automatic check_outs(input string tag, input q_t q, input int n, input int af,
                             input logic [7:0] cnt, input logic [1:0] v, input logic [63:0] d,
                             input logic f, input logic a);
      logic [1:0]  ev;
      logic [63:0] ed;
      ev = '0;
      ed = '0;
      for (int k = 0; k < 2; k++) begin
         if (q.size() > k) begin
            ev[k] = 1'b1;
            ed[k*32 +: 32] = q[k];
         end
      end
      chk({tag, "_count"}, 64'(cnt), 64'(q.size()));
      chk({tag, "_valid"}, 64'(v), 64'(ev));
      chk({tag, "_data"}, d, ed);
      chk({tag, "_full"}, 64'(f), 64'(q.size() == n));
      chk({tag, "_afull"}, 64'(a), 64'(q.size() >= af));
   endtask

   // One clock: apply inputs, check combinational ack, clock, check state.
   task automatic cycle(input logic fl, input logic rs, input logic [1:0] pc, input logic [1:0] pp,
                        input logic [31:0] d0, input logic [31:0] d1,
                        output logic ack8_act, output logic ack5_exp);
      logic e8, e5;
      q_t   t;
      flush = fl; rst = rs; push_cnt = pc; pop_cnt = pp; data = {d1, d0};
      #1;
      e8 = model_ack(q8.size(), 8, fl, rs, int'(pc), int'(pp));
      e5 = model_ack(q5.size(), 5, fl, rs, int'(pc), int'(pp));
      chk("ack8", 64'(if8.push_ack_o), 64'(e8));
      chk("ack5", 64'(if5.push_ack_o), 64'(e5));
      ack8_act = if8.push_ack_o;
      ack5_exp = e5;
      @(posedge clk);
      #1;
      model_upd(q8, 8, fl, rs, int'(pc), int'(pp), {d1, d0}, t); q8 = t;
      model_upd(q5, 5, fl, rs, int'(pc), int'(pp), {d1, d0}, t); q5 = t;
      check_outs("d8", q8, 8, 6, c8, if8.valid_o, if8.data_o, if8.full_o, if8.almost_full_o);
      check_outs("d5", q5, 5, 4, c5, if5.valid_o, if5.data_o, if5.full_o, if5.almost_full_o);
   endtask

   task automatic add(input logic fl, input logic rs, input logic [1:0] pc, input logic [1:0] pp,
                      input logic [31:0] d0, input logic [31:0] d1, input logic ack,
                      input int cnt, input logic [1:0] v, input logic [31:0] l0);
      vec_t r;
      r.fl = fl; r.rs = rs; r.pc = pc; r.pp = pp; r.d0 = d0; r.d1 = d1;
      r.ack = ack; r.cnt = cnt; r.v = v; r.l0 = l0;
      tbl.push_back(r);
   endtask

   initial begin
      logic a8, a5;
      int   pushed, popped, budget;
      rst = 1'b1; flush = 1'b0; push_cnt = '0; pop_cnt = '0; data = '0;
      @(posedge clk); #1;

      // Directed table: expected ack/count/valid/lane0 for the 8-deep instance.
      add(0,1,0,0,   0,   0, 0,0,2'b00,   0);
      add(0,1,0,0,   0,   0, 0,0,2'b00,   0);
      add(0,0,2,0, 'hA, 'hB, 1,2,2'b11, 'hA);
      add(0,0,2,0, 'hA, 'hB, 1,4,2'b11, 'hA);
      add(0,0,2,0, 'hA, 'hB, 1,6,2'b11, 'hA);
      add(0,0,2,0, 'hA, 'hB, 1,8,2'b11, 'hA);
      add(0,0,1,0, 'hE,   0, 0,8,2'b11, 'hA);
      add(0,0,2,2, 'hC, 'hD, 1,8,2'b11, 'hA);
      add(0,0,0,2,   0,   0, 0,6,2'b11, 'hA);
      add(0,0,0,2,   0,   0, 0,4,2'b11, 'hA);
      add(0,0,0,2,   0,   0, 0,2,2'b11, 'hC);
      add(0,0,0,2,   0,   0, 0,0,2'b00,   0);
      add(0,0,1,2,'h55,   0, 1,1,2'b01,'h55);
      add(0,0,2,0,'h10,'h11, 1,3,2'b11,'h55);
      add(0,0,2,0,'h12,'h13, 1,5,2'b11,'h55);
      add(1,0,2,1,'h30,'h31, 0,0,2'b00,   0);
      add(0,0,1,0,'h66,   0, 1,1,2'b01,'h66);
      add(0,0,2,0,'h20,'h21, 1,3,2'b11,'h66);
      add(0,1,2,0,'h40,'h41, 0,0,2'b00,   0);
      add(0,0,1,0,'h77,   0, 1,1,2'b01,'h77);

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].fl, tbl[i].rs, tbl[i].pc, tbl[i].pp, tbl[i].d0, tbl[i].d1, a8, a5);
         chk($sformatf("tbl%0d_ack", i), 64'(a8), 64'(tbl[i].ack));
         chk($sformatf("tbl%0d_count", i), 64'(c8), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d_valid", i), 64'(if8.valid_o), 64'(tbl[i].v));
         chk($sformatf("tbl%0d_lane0", i), 64'(if8.data_o[31:0]), 64'(tbl[i].l0));
      end
      chk("tbl_full_after_fill", 64'(tbl.size()), 64'(20));

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 25) == 0, ($urandom % 50) == 0, 2'($urandom_range(0, 2)),
               2'($urandom_range(0, 2)), $urandom, $urandom, a8, a5);
      end

      // Ordered stream 0..19 through the 5-deep instance across pointer wraps.
      cycle(0, 1, 0, 0, 0, 0, a8, a5);
      pushed = 0; popped = 0; budget = 0;
      while (popped < 20 && budget < 200) begin
         logic [1:0] pc;
         if (if5.valid_o[0]) begin
            chk("stream5_order", 64'(if5.data_o[31:0]), 64'(popped));
            popped++;
         end
         pc = (20 - pushed >= 2) ? 2'd2 : 2'(20 - pushed);
         cycle(0, 0, pc, 2'd1, 32'(pushed), 32'(pushed + 1), a8, a5);
         if (a5) pushed += int'(pc);
         budget++;
      end
      chk("stream5_done", 64'(popped), 64'(20));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
